// File: rtl/pads_cfg_loader_pkg.sv
// Shared constants, state encoding and error codes for the pad
// output-enable bulk loader.
package pads_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_6000;
    localparam int          DEF_NUM_PADS  = 38;
    localparam int          DEF_TIMEOUT   = 255;
    localparam int          IDX_W         = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_GAP,
        ST_RD_REQ,
        ST_RD_GAP,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_MISMATCH = 2'd2
    } err_code_t;

endpackage

// File: rtl/pads_cfg_loader_if.sv
// Wishbone classic single-access bus between the loader (master) and the
// pad-configuration slave.
interface pads_cfg_loader_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, dat_r
    );

endinterface

// File: rtl/pads_cfg_loader_xfer.sv
// Single Wishbone access engine: drives the bus while req is high, reports
// ack or an ack timeout. The bus is fully quiet (all zero) whenever req is low.
module wb_single_xfer
    import pads_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               req,
    input  logic               we,
    input  logic [31:0]        adr,
    input  logic [31:0]        wdata,
    pads_cfg_loader_if.master  wbm,
    output logic               xfer_done,
    output logic               xfer_timeout,
    output logic [31:0]        rdata
);

    logic [7:0] tmr;

    // Down-counter reloads whenever no access is pending, so every REQ
    // entry starts from the full budget.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmr <= 8'(TIMEOUT);
        end else if (!req) begin
            tmr <= 8'(TIMEOUT);
        end else if (tmr != 8'd0) begin
            tmr <= tmr - 8'd1;
        end
    end

    assign wbm.cyc   = req;
    assign wbm.stb   = req;
    assign wbm.we    = req & we;
    assign wbm.sel   = req ? 4'hF : 4'h0;
    assign wbm.adr   = req ? adr : 32'd0;
    assign wbm.dat_w = req ? wdata : 32'd0;

    assign xfer_done    = req & wbm.ack;
    assign xfer_timeout = req & ~wbm.ack & (tmr == 8'd0);
    assign rdata        = wbm.dat_r;

endmodule

// File: rtl/pads_cfg_loader.sv
// Walks all pad output-enable registers with single writes, optionally reads
// them back and compares bit 0, then reports done/error to housekeeping.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; bus quiet
// ST_WR_REQ | write access of pad idx in flight
// ST_WR_GAP | one idle bus cycle after a write ack; advance idx
// ST_RD_REQ | read-back access of pad idx in flight
// ST_RD_GAP | one idle bus cycle after a read ack; advance idx
// ST_FINISH | done pulse; back to idle next cycle
module pads_cfg_loader
    import pads_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          NUM_PADS  = DEF_NUM_PADS,
    parameter int          TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 verify_en,
    input  logic [NUM_PADS-1:0]  oen_target,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [IDX_W-1:0]     err_idx,
    pads_cfg_loader_if.master    wbm
);

    state_t               state, state_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [NUM_PADS-1:0]  tgt_q, tgt_d;
    logic                 verify_q, verify_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [IDX_W-1:0]     eidx_q, eidx_d;

    logic                 req, we;
    logic                 xfer_done, xfer_timeout;
    logic [31:0]          rdata;
    logic                 tgt_bit, last_pad;
    logic                 unused_rdata;

    assign tgt_bit      = tgt_q[idx];
    assign last_pad     = (idx == IDX_W'(NUM_PADS - 1));
    assign unused_rdata = ^rdata[31:1];

    wb_single_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .req          (req),
        .we           (we),
        .adr          (BASE_ADDR + {{(32-IDX_W){1'b0}}, idx}),
        .wdata        ({31'd0, tgt_bit}),
        .wbm          (wbm),
        .xfer_done    (xfer_done),
        .xfer_timeout (xfer_timeout),
        .rdata        (rdata)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            idx      <= '0;
            tgt_q    <= '0;
            verify_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            eidx_q   <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            tgt_q    <= tgt_d;
            verify_q <= verify_d;
            err_q    <= err_d;
            code_q   <= code_d;
            eidx_q   <= eidx_d;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        tgt_d    = tgt_q;
        verify_d = verify_q;
        err_d    = err_q;
        code_d   = code_q;
        eidx_d   = eidx_q;
        req      = 1'b0;
        we       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    tgt_d    = oen_target;
                    verify_d = verify_en;
                    err_d    = 1'b0;
                    code_d   = ERR_NONE;
                    eidx_d   = '0;
                    idx_d    = '0;
                    state_d  = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                req = 1'b1;
                we  = 1'b1;
                if (xfer_done) begin
                    state_d = ST_WR_GAP;
                end else if (xfer_timeout) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    eidx_d  = idx;
                    state_d = ST_FINISH;
                end
            end
            ST_WR_GAP: begin
                if (last_pad) begin
                    idx_d   = '0;
                    state_d = verify_q ? ST_RD_REQ : ST_FINISH;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                req = 1'b1;
                if (xfer_done) begin
                    if (rdata[0] != tgt_bit) begin
                        err_d   = 1'b1;
                        code_d  = ERR_MISMATCH;
                        eidx_d  = idx;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RD_GAP;
                    end
                end else if (xfer_timeout) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    eidx_d  = idx;
                    state_d = ST_FINISH;
                end
            end
            ST_RD_GAP: begin
                if (last_pad) begin
                    idx_d   = '0;
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FINISH);
    assign err      = err_q;
    assign err_code = code_q;
    assign err_idx  = eidx_q;

endmodule

// File: tb/tb_pads_cfg_loader.sv
// Directed bench for pads_cfg_loader: pad-config slave model with fault
// injection, access scoreboard, and cycle-accurate done/status checks.
module tb_pads_cfg_loader;
    import pads_pkg::*;

    localparam int          NP   = 38;
    localparam logic [31:0] BASE = 32'h3000_6000;
    localparam int          TO   = 255;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          start = 1'b0;
    logic          verify_en = 1'b0;
    logic [NP-1:0] oen_target = '0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [5:0]    err_idx;

    pads_cfg_loader_if bus();

    pads_cfg_loader #(.BASE_ADDR(BASE), .NUM_PADS(NP), .TIMEOUT(TO)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start      (start),
        .verify_en  (verify_en),
        .oen_target (oen_target),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_idx    (err_idx),
        .wbm        (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Pad-config slave: registered ack, optional never-ack pad and
    // optional inverted read-back pad.
    logic [NP-1:0] pad_oe;
    int            noack_idx = -1;
    int            inv_idx = -1;
    logic [5:0]    sidx;
    assign sidx = bus.adr[5:0];

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bus.ack   <= 1'b0;
            bus.dat_r <= 32'd0;
            pad_oe    <= '0;
        end else begin
            bus.ack <= 1'b0;
            if (bus.cyc && bus.stb && !bus.ack && int'(sidx) != noack_idx) begin
                bus.ack <= 1'b1;
                if (bus.we)
                    pad_oe[sidx] <= bus.dat_w[0];
                else
                    bus.dat_r <= {31'b0, pad_oe[sidx] ^ (int'(sidx) == inv_idx)};
            end
        end
    end

    int   total = 0;
    int   bad = 0;
    int   rd_cnt = 0;
    logic req_d = 1'b0;
    logic [68:0] exp_q[$];

    function automatic logic [68:0] acc(input logic we, input int i, input logic b);
        return {we, BASE + 32'(i), {31'd0, b}, 4'hF};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int n, input logic [NP-1:0] tgt);
        for (int i = 0; i < n; i++) exp_q.push_back(acc(1'b1, i, tgt[i]));
    endtask

    task automatic push_rd(input int n, input logic [NP-1:0] tgt);
        for (int i = 0; i < n; i++) exp_q.push_back(acc(1'b0, i, tgt[i]));
    endtask

    // Each new access start is popped against the expected trace.
    always @(negedge wb_clk_i) begin
        if (bus.cyc && bus.stb && !req_d) begin
            logic [68:0] obs;
            obs = {bus.we, bus.adr, bus.dat_w, bus.sel};
            if (!bus.we) rd_cnt <= rd_cnt + 1;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_access: observed=%0h expected=none", obs);
            end
            if (exp_q.size() != 0) chk("access", 96'(obs), 96'(exp_q.pop_front()));
        end
        req_d <= bus.cyc && bus.stb;
    end

    // mode 0: plain run; 1: extra start in cycle 50; 2: reset in cycle 61.
    task automatic run_seq(input logic [NP-1:0] tgt, input logic ver, input int mode,
                           output int done_cyc, output int ndone);
        done_cyc   = -1;
        ndone      = 0;
        oen_target = tgt;
        verify_en  = ver;
        start      = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge wb_clk_i);
            #1;
            if (k == 1) begin
                start = 1'b0;
                chk("busy_cycle1", 96'(busy), 96'(1));
                chk("err_cleared", 96'(err), 96'(0));
            end
            if (mode == 1 && k == 50) begin
                start      = 1'b1;
                oen_target = ~tgt;
                verify_en  = ~ver;
            end
            if (mode == 1 && k == 51) start = 1'b0;
            if (mode == 2 && k == 61) wb_rst_i = 1'b1;
            if (mode == 2 && k == 62) begin
                chk("rst_cyc_stb_busy", 96'({bus.cyc, bus.stb, busy}), 96'(0));
                wb_rst_i = 1'b0;
                break;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    chk("busy_at_done", 96'(busy), 96'(1));
                end
            end
            if (done_cyc >= 0 && k >= done_cyc + 4) break;
        end
        if (mode != 2) chk("busy_after_done", 96'(busy), 96'(0));
    endtask

    initial begin
        int dc, nd, rd0;
        logic [NP-1:0] tgt;

        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("reset_bus", 96'({bus.cyc, bus.stb, bus.we, bus.sel, bus.adr, bus.dat_w}), 96'(0));
        chk("reset_status", 96'({busy, done, err, err_code, err_idx}), 96'(0));
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // Write + verify with an arbitrary pattern
        tgt = 38'h3F_C03F_FFA1;
        push_wr(NP, tgt);
        push_rd(NP, tgt);
        rd0 = rd_cnt;
        run_seq(tgt, 1'b1, 0, dc, nd);
        chk("verify_done_cycle", 96'(dc), 96'(229));
        chk("verify_ndone", 96'(nd), 96'(1));
        chk("verify_status", 96'({err, err_code, err_idx}), 96'(0));
        chk("verify_pads", 96'(pad_oe), 96'(tgt));
        chk("verify_reads", 96'(rd_cnt - rd0), 96'(NP));
        chk("verify_queue", 96'(exp_q.size()), 96'(0));

        // Write only, all ones
        tgt = '1;
        push_wr(NP, tgt);
        rd0 = rd_cnt;
        run_seq(tgt, 1'b0, 0, dc, nd);
        chk("wo_done_cycle", 96'(dc), 96'(115));
        chk("wo_reads", 96'(rd_cnt - rd0), 96'(0));
        chk("wo_pads", 96'(pad_oe), 96'(tgt));
        chk("wo_queue", 96'(exp_q.size()), 96'(0));

        // Pad 5 never acked
        noack_idx = 5;
        tgt = '0;
        push_wr(6, tgt);
        rd0 = rd_cnt;
        run_seq(tgt, 1'b1, 0, dc, nd);
        chk("to_done_cycle", 96'(dc), 96'(272));
        chk("to_ndone", 96'(nd), 96'(1));
        chk("to_status", 96'({err, err_code, err_idx}), 96'({1'b1, 2'd1, 6'd5}));
        chk("to_cyc_low", 96'(bus.cyc), 96'(0));
        chk("to_pads", 96'(pad_oe), 96'(38'h3F_FFFF_FFE0));
        chk("to_reads", 96'(rd_cnt - rd0), 96'(0));
        chk("to_queue", 96'(exp_q.size()), 96'(0));
        noack_idx = -1;

        // Read-back of pad 12 inverted
        inv_idx = 12;
        tgt = 38'h15_5555_5555;
        push_wr(NP, tgt);
        push_rd(13, tgt);
        rd0 = rd_cnt;
        run_seq(tgt, 1'b1, 0, dc, nd);
        chk("mm_done_cycle", 96'(dc), 96'(153));
        chk("mm_ndone", 96'(nd), 96'(1));
        chk("mm_status", 96'({err, err_code, err_idx}), 96'({1'b1, 2'd2, 6'd12}));
        chk("mm_reads", 96'(rd_cnt - rd0), 96'(13));
        chk("mm_queue", 96'(exp_q.size()), 96'(0));
        inv_idx = -1;

        // Second start while busy is ignored
        tgt = 38'h2A_1234_5678;
        push_wr(NP, tgt);
        rd0 = rd_cnt;
        run_seq(tgt, 1'b0, 1, dc, nd);
        chk("busy_start_done_cycle", 96'(dc), 96'(115));
        chk("busy_start_ndone", 96'(nd), 96'(1));
        chk("busy_start_err", 96'(err), 96'(0));
        chk("busy_start_pads", 96'(pad_oe), 96'(tgt));
        chk("busy_start_reads", 96'(rd_cnt - rd0), 96'(0));
        chk("busy_start_queue", 96'(exp_q.size()), 96'(0));

        // Reset during WR_REQ of pad 20, then a fresh run
        tgt = 38'h0F_0F0F_0F0F;
        push_wr(21, tgt);
        run_seq(tgt, 1'b0, 2, dc, nd);
        chk("rst_no_done", 96'(nd), 96'(0));
        repeat (4) @(posedge wb_clk_i);
        #1;
        chk("rst_idle_bus", 96'({bus.cyc, bus.stb, busy, done, err}), 96'(0));
        chk("rst_queue", 96'(exp_q.size()), 96'(0));
        push_wr(NP, tgt);
        run_seq(tgt, 1'b0, 0, dc, nd);
        chk("rst_fresh_done_cycle", 96'(dc), 96'(115));
        chk("rst_fresh_pads", 96'(pad_oe), 96'(tgt));
        chk("rst_fresh_queue", 96'(exp_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
